// File: rtl/common_pkg.sv
// ----------------------------------------------------------------------------
// common_pkg
// Shared constants and types for the PET keyboard / PIA glue logic.
//   - Data width, keyboard matrix geometry and Wishbone base address.
//   - PIA (6520) register-select encodings used by the CPU-side snoop.
//   - Keyboard row type and the "no key pressed" column value.
// ----------------------------------------------------------------------------
package common_pkg;

    localparam int DATA_WIDTH = 8;

    // Keyboard matrix geometry: 10 rows, addressed by the low 4 WB address bits.
    localparam int KBD_ROW_COUNT     = 10;
    localparam int KBD_ADDR_WIDTH    = 4;
    localparam int KBD_ROW_SEL_WIDTH = 4;

    // Wishbone window for the keyboard responder (decoded by the interconnect).
    localparam logic [15:0] WB_KBD_BASE = 16'h0200;

    // 6520 PIA register select (RS1:RS0). PORTA shares RS=0 with DDRA; the
    // CRA bit 2 chooses which one a write reaches.
    localparam int PIA_RS_WIDTH = 2;
    localparam logic [PIA_RS_WIDTH-1:0] PIA_PORTA = 2'd0;
    localparam logic [PIA_RS_WIDTH-1:0] PIA_CRA   = 2'd1;
    localparam logic [PIA_RS_WIDTH-1:0] PIA_PORTB = 2'd2;
    localparam logic [PIA_RS_WIDTH-1:0] PIA_CRB   = 2'd3;

    // Bit of CRA that selects port register (1) versus DDR (0).
    localparam int PIA_CR_DDR_BIT = 2;

    typedef logic [DATA_WIDTH-1:0] kbd_row_t;

    // Keys are active-low, so all ones means nothing is pressed.
    localparam kbd_row_t KBD_COL_RESET = 8'hFF;

endpackage

// File: rtl/pia_row_select.sv
// ----------------------------------------------------------------------------
// pia_row_select
// Snoops completed 6502 writes to PIA1 and tracks which keyboard row the
// CPU has selected through port A.
//   clock_i, reset_ni   clock / async active-low reset
//   pia1_cs_i           CPU access targets PIA1
//   cpu_rs_i            PIA register select
//   cpu_we_i            CPU write
//   cpu_strobe_i        one-cycle pulse marking the completed CPU access
//   cpu_data_i          CPU write data
//   row_sel_o           currently selected keyboard row (may be >= row count)
//   cra2_o              CRA bit 2: 1 = port A register, 0 = DDRA
// ----------------------------------------------------------------------------
module pia_row_select
    import common_pkg::*;
#(
    parameter int DATA_WIDTH = common_pkg::DATA_WIDTH
) (
    input  logic                         clock_i,
    input  logic                         reset_ni,
    input  logic                         pia1_cs_i,
    input  logic [PIA_RS_WIDTH-1:0]      cpu_rs_i,
    input  logic                         cpu_we_i,
    input  logic                         cpu_strobe_i,
    input  logic [DATA_WIDTH-1:0]        cpu_data_i,
    output logic [KBD_ROW_SEL_WIDTH-1:0] row_sel_o,
    output logic                         cra2_o
);

    logic                         cra2_q, cra2_d;
    logic [KBD_ROW_SEL_WIDTH-1:0] row_sel_q, row_sel_d;
    logic                         snoop_wr;

    // Only the row-select nibble and the DDR-select bit matter here.
    logic unused_cpu_data;
    assign unused_cpu_data = ^cpu_data_i[DATA_WIDTH-1:KBD_ROW_SEL_WIDTH];

    assign snoop_wr = cpu_strobe_i & pia1_cs_i & cpu_we_i;

    always_comb begin
        cra2_d    = cra2_q;
        row_sel_d = row_sel_q;
        if (snoop_wr) begin
            if (cpu_rs_i == PIA_CRA) begin
                cra2_d = cpu_data_i[PIA_CR_DDR_BIT];
            end else if (cpu_rs_i == PIA_PORTA && cra2_q) begin
                // With cra2 clear the write lands in DDRA, not the port.
                row_sel_d = cpu_data_i[KBD_ROW_SEL_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cra2_q    <= 1'b0;
            row_sel_q <= '0;
        end else begin
            cra2_q    <= cra2_d;
            row_sel_q <= row_sel_d;
        end
    end

    assign row_sel_o = row_sel_q;
    assign cra2_o    = cra2_q;

endmodule

// File: rtl/kbd_matrix_responder.sv
// ----------------------------------------------------------------------------
// kbd_matrix_responder
// Wishbone responder holding the 10-row PET keyboard matrix written by the
// MCU, plus the column byte for the row the 6502 selected via PIA1 port A.
//
// Build option: define KBD_WB_READBACK_EN to let Wishbone reads return stored
// row data. Without it wb_data_o is tied to 0 (reads are still acked).
//
// Ports
//   clock_i, reset_ni              clock / async active-low reset
//   wb_addr_i                      row index (base decoded upstream)
//   wb_data_i / wb_data_o          write data / read data (valid with ack)
//   wb_we_i, wb_cyc_i, wb_stb_i    Wishbone request
//   wb_ack_o                       acknowledge, one cycle after stb
//   wb_stall_o                     always 0
//   pia1_cs_i, cpu_rs_i, cpu_we_i,
//   cpu_strobe_i, cpu_data_i       snooped 6502 PIA1 access
//   kbd_col_o                      registered column byte (active-low keys)
//   dbg_ack_state_o                ack FSM state (0 = IDLE, 1 = ACK)
//
// Handshake: a request is cyc&stb sampled while IDLE. The following cycle is
// ACK with wb_ack_o high; the FSM then returns to IDLE regardless of cyc/stb,
// so acks are never back-to-back. Writes are applied on the accepting edge.
// ----------------------------------------------------------------------------
module kbd_matrix_responder
    import common_pkg::*;
#(
    parameter int DATA_WIDTH = common_pkg::DATA_WIDTH,
    parameter int ROW_COUNT  = KBD_ROW_COUNT
) (
    input  logic                      clock_i,
    input  logic                      reset_ni,
    input  logic [KBD_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    output logic                      wb_ack_o,
    output logic                      wb_stall_o,
    input  logic                      pia1_cs_i,
    input  logic [PIA_RS_WIDTH-1:0]   cpu_rs_i,
    input  logic                      cpu_we_i,
    input  logic                      cpu_strobe_i,
    input  logic [DATA_WIDTH-1:0]     cpu_data_i,
    output logic [DATA_WIDTH-1:0]     kbd_col_o,
    output logic                      dbg_ack_state_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    // One extra bit so ROW_COUNT itself is representable in the compares.
    localparam logic [KBD_ADDR_WIDTH:0]    ADDR_LIMIT = (KBD_ADDR_WIDTH + 1)'(ROW_COUNT);
    localparam logic [KBD_ROW_SEL_WIDTH:0] SEL_LIMIT  = (KBD_ROW_SEL_WIDTH + 1)'(ROW_COUNT);

    logic [0:0] state_q, state_d;
    kbd_row_t   rows_q [ROW_COUNT];
    kbd_row_t   rows_d [ROW_COUNT];
    kbd_row_t   col_q, col_d;

    logic                         accept;
    logic                         addr_ok;
    logic                         sel_ok;
    logic [KBD_ROW_SEL_WIDTH-1:0] row_sel;
    logic                         cra2;

    pia_row_select #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pia_row_select (
        .clock_i      (clock_i),
        .reset_ni     (reset_ni),
        .pia1_cs_i    (pia1_cs_i),
        .cpu_rs_i     (cpu_rs_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_strobe_i (cpu_strobe_i),
        .cpu_data_i   (cpu_data_i),
        .row_sel_o    (row_sel),
        .cra2_o       (cra2)
    );

    // cra2 is only needed inside the snoop block; kept as a visible net for debug.
    logic unused_cra2;
    assign unused_cra2 = cra2;

    assign accept  = (state_q == ST_IDLE) && wb_cyc_i && wb_stb_i;
    assign addr_ok = ({1'b0, wb_addr_i} < ADDR_LIMIT);
    assign sel_ok  = ({1'b0, row_sel} < SEL_LIMIT);

    always_comb begin
        state_d = ST_IDLE;
        if (accept) begin
            state_d = ST_ACK;
        end

        rows_d = rows_q;
        // Writes to rows past the matrix are dropped but still acked.
        if (accept && wb_we_i && addr_ok) begin
            rows_d[wb_addr_i] = wb_data_i;
        end

        // Uses the registered rows, so a same-cycle WB write is seen one
        // cycle later on the column output.
        col_d = KBD_COL_RESET;
        if (sel_ok) begin
            col_d = rows_q[row_sel];
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            col_q   <= KBD_COL_RESET;
            for (int i = 0; i < ROW_COUNT; i++) begin
                rows_q[i] <= KBD_COL_RESET;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            rows_q  <= rows_d;
        end
    end

`ifdef KBD_WB_READBACK_EN
    kbd_row_t rd_q, rd_d;

    always_comb begin
        rd_d = rd_q;
        if (accept && !wb_we_i) begin
            rd_d = addr_ok ? rows_q[wb_addr_i] : KBD_COL_RESET;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign wb_data_o = rd_q;
`else
    assign wb_data_o = '0;
`endif

    assign wb_ack_o        = (state_q == ST_ACK);
    assign wb_stall_o      = 1'b0;
    assign kbd_col_o       = col_q;
    assign dbg_ack_state_o = state_q[0];

endmodule

// File: tb/tb_kbd_matrix_responder.sv
module tb_kbd_matrix_responder;
    import common_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock_i = 1'b0;
    logic reset_ni;
    always #5 clock_i = ~clock_i;

    logic [KBD_ADDR_WIDTH-1:0] wb_addr_i;
    logic [7:0]                wb_data_i, wb_data_o;
    logic                      wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_stall_o;
    logic                      pia1_cs_i, cpu_we_i, cpu_strobe_i;
    logic [PIA_RS_WIDTH-1:0]   cpu_rs_i;
    logic [7:0]                cpu_data_i, kbd_col_o;
    logic                      dbg_ack_state_o;

    kbd_matrix_responder dut (
        .clock_i         (clock_i),
        .reset_ni        (reset_ni),
        .wb_addr_i       (wb_addr_i),
        .wb_data_i       (wb_data_i),
        .wb_data_o       (wb_data_o),
        .wb_we_i         (wb_we_i),
        .wb_cyc_i        (wb_cyc_i),
        .wb_stb_i        (wb_stb_i),
        .wb_ack_o        (wb_ack_o),
        .wb_stall_o      (wb_stall_o),
        .pia1_cs_i       (pia1_cs_i),
        .cpu_rs_i        (cpu_rs_i),
        .cpu_we_i        (cpu_we_i),
        .cpu_strobe_i    (cpu_strobe_i),
        .cpu_data_i      (cpu_data_i),
        .kbd_col_o       (kbd_col_o),
        .dbg_ack_state_o (dbg_ack_state_o)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    // 16 addressable rows; only 0..9 are storage, 10..15 always read as no-key.
    logic [7:0] model_rows [16];
    logic       model_cra2;
    logic [3:0] model_sel;
    logic [7:0] exp_q [$];

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) model_rows[i] = 8'hFF;
        model_cra2 = 1'b0;
        model_sel  = 4'd0;
    endfunction

    function automatic void model_wb_write(input logic [3:0] a, input logic [7:0] d);
        if (a < 4'd10) model_rows[a] = d;
    endfunction

    function automatic void model_cpu_write(input logic [1:0] rs, input logic [7:0] d);
        if (rs == PIA_CRA) model_cra2 = d[2];
        else if (rs == PIA_PORTA && model_cra2) model_sel = d[3:0];
    endfunction

    function automatic logic [7:0] exp_col();
        return model_rows[model_sel];
    endfunction

    function automatic logic [7:0] exp_rd(input logic [3:0] a);
`ifdef KBD_WB_READBACK_EN
        return model_rows[a];
`else
        return 8'h00;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        wb_addr_i = '0; wb_data_i = '0; wb_we_i = 0; wb_cyc_i = 0; wb_stb_i = 0;
        pia1_cs_i = 0; cpu_rs_i = '0; cpu_we_i = 0; cpu_strobe_i = 0; cpu_data_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_ni = 1'b0;
        repeat (2) @(negedge clock_i);
        reset_ni = 1'b1;
        model_reset();
    endtask

    task automatic wb_xfer(input logic we, input logic [3:0] a, input logic [7:0] d, input string tag);
        logic [7:0] want;
        int waited;
        @(negedge clock_i);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_addr_i = a; wb_data_i = d;
        if (!we) exp_q.push_back(exp_rd(a));
        else model_wb_write(a, d);
        @(negedge clock_i);
        checks++;
        if (wb_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ack_latency: got %b want 1", tag, wb_ack_o);
            waited = 0;
            while (wb_ack_o !== 1'b1 && waited < 4) begin
                @(negedge clock_i);
                waited++;
            end
        end
        if (!we) begin
            want = exp_q.pop_front();
            checks++;
            if (wb_data_o !== want) begin
                errors++;
                $display("FAIL %s rd_data row %0d: got %h want %h", tag, a, wb_data_o, want);
            end
        end
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        @(negedge clock_i);
        checks++;
        if (wb_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL %s ack_drop: got %b want 0", tag, wb_ack_o);
        end
    endtask

    // The column must not move in the cycle of the strobe edge itself.
    task automatic cpu_write(input logic [1:0] rs, input logic [7:0] d, input string tag);
        logic [7:0] old;
        old = exp_col();
        @(negedge clock_i);
        pia1_cs_i = 1; cpu_we_i = 1; cpu_strobe_i = 1; cpu_rs_i = rs; cpu_data_i = d;
        model_cpu_write(rs, d);
        @(negedge clock_i);
        pia1_cs_i = 0; cpu_we_i = 0; cpu_strobe_i = 0;
        checks++;
        if (kbd_col_o !== old) begin
            errors++;
            $display("FAIL %s col_lag: got %h want %h", tag, kbd_col_o, old);
        end
    endtask

    task automatic check_col(input string tag);
        checks++;
        if (kbd_col_o !== exp_col()) begin
            errors++;
            $display("FAIL %s kbd_col: got %h want %h", tag, kbd_col_o, exp_col());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (wb_ack_o !== 1'b0 || wb_data_o !== 8'h00 || dbg_ack_state_o !== 1'b0 || wb_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b data=%h state=%b stall=%b want 0 00 0 0",
                     wb_ack_o, wb_data_o, dbg_ack_state_o, wb_stall_o);
        end
        check_col("reset");
        wb_xfer(1'b0, 4'd3, 8'h00, "reset_rd_row3");
        check_col("reset_after_rd");
    endtask

    task automatic test_select_row();
        wb_xfer(1'b1, 4'd9, 8'hFE, "wr_row9");
        cpu_write(PIA_CRA, 8'h04, "cra_04");
        cpu_write(PIA_PORTA, 8'h09, "porta_09");
        @(negedge clock_i);
        check_col("sel_row9");
        checks++;
        if (kbd_col_o !== 8'hFE) begin
            errors++;
            $display("FAIL sel_row9_const: got %h want fe", kbd_col_o);
        end
    endtask

    task automatic test_ddr_and_oob();
        cpu_write(PIA_CRA, 8'h00, "cra_00");
        cpu_write(PIA_PORTA, 8'h05, "ddra_05");
        @(negedge clock_i);
        check_col("ddr_keeps_sel");
        wb_xfer(1'b1, 4'd12, 8'h00, "wr_row12");
        wb_xfer(1'b0, 4'd12, 8'h00, "rd_row12");
    endtask

    task automatic test_same_cycle();
        logic [7:0] old, nv;
        cpu_write(PIA_CRA, 8'h04, "cra_on");
        cpu_write(PIA_PORTA, 8'h02, "porta_02");
        @(negedge clock_i);
        check_col("sel_row2");
        // WB write of the selected row while the CPU reads PORTB.
        old = exp_col();
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_addr_i = 4'd2; wb_data_i = 8'hBF;
        pia1_cs_i = 1; cpu_strobe_i = 1; cpu_we_i = 0; cpu_rs_i = PIA_PORTB;
        model_wb_write(4'd2, 8'hBF);
        @(negedge clock_i);
        idle_inputs();
        checks++;
        if (kbd_col_o !== old || wb_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_old: col=%h ack=%b want %h 1", kbd_col_o, wb_ack_o, old);
        end
        @(negedge clock_i);
        check_col("same_cycle_new");
        // Row select change and WB write to the new row on the same edge.
        old = exp_col();
        nv  = 8'($urandom_range(0, 254));
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_addr_i = 4'd4; wb_data_i = nv;
        pia1_cs_i = 1; cpu_strobe_i = 1; cpu_we_i = 1; cpu_rs_i = PIA_PORTA; cpu_data_i = 8'h04;
        model_wb_write(4'd4, nv);
        model_cpu_write(PIA_PORTA, 8'h04);
        @(negedge clock_i);
        idle_inputs();
        checks++;
        if (kbd_col_o !== old) begin
            errors++;
            $display("FAIL sel_and_wr_old: got %h want %h", kbd_col_o, old);
        end
        @(negedge clock_i);
        check_col("sel_and_wr_new");
    endtask

    task automatic test_back_to_back();
        logic [0:3] pattern;
        logic prev;
        pattern = 4'b1010;
        prev = 1'b0;
        @(negedge clock_i);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_addr_i = 4'd9;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock_i);
            checks++;
            if (wb_ack_o !== pattern[k] || (prev && wb_ack_o)) begin
                errors++;
                $display("FAIL b2b_ack[%0d]: got %b want %b", k, wb_ack_o, pattern[k]);
            end
            if (k == 0) begin
                checks++;
                if (wb_data_o !== exp_rd(4'd9)) begin
                    errors++;
                    $display("FAIL b2b_data: got %h want %h", wb_data_o, exp_rd(4'd9));
                end
            end
            prev = wb_ack_o;
            if (k == 2) idle_inputs();
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [7:0] d;
        for (int n = 0; n < 60; n++) begin
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            case ($urandom_range(0, 3))
                0: wb_xfer(1'b1, a, d, "rnd_wr");
                1: wb_xfer(1'b0, a, 8'h00, "rnd_rd");
                2: cpu_write(PIA_CRA, {5'd0, ($urandom_range(0, 3) != 0), 2'd0}, "rnd_cra");
                default: cpu_write(PIA_PORTA, d, "rnd_porta");
            endcase
            @(negedge clock_i);
            check_col("rnd");
        end
        // Make sure every row holds a non-idle value before the reset test.
        for (int r = 0; r < 10; r++) wb_xfer(1'b1, 4'(r), 8'(r + 8'h10), "fill");
        cpu_write(PIA_CRA, 8'h04, "fill_cra");
        cpu_write(PIA_PORTA, 8'h03, "fill_porta");
        @(negedge clock_i);
        check_col("fill_sel3");
    endtask

    task automatic test_reset_mid();
        @(negedge clock_i);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_addr_i = 4'd1; wb_data_i = 8'h33;
        @(posedge clock_i);
        #2 reset_ni = 1'b0;
        #1;
        checks++;
        if (wb_ack_o !== 1'b0 || kbd_col_o !== 8'hFF || wb_data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: ack=%b col=%h data=%h want 0 ff 00", wb_ack_o, kbd_col_o, wb_data_o);
        end
        @(negedge clock_i);
        idle_inputs();
        reset_ni = 1'b1;
        model_reset();
        for (int r = 0; r < 16; r++) wb_xfer(1'b0, 4'(r), 8'h00, "post_reset_rd");
        check_col("post_reset");
        // After reset cra2 is 0 again, so a PORTA write must not select a row.
        wb_xfer(1'b1, 4'd0, 8'h7E, "post_reset_wr0");
        cpu_write(PIA_PORTA, 8'h05, "post_reset_porta");
        @(negedge clock_i);
        check_col("post_reset_sel0");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_select_row();
        test_ddr_and_oob();
        test_same_cycle();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kbd_matrix_responder.md
# kbd_matrix_responder

Wishbone responder at `WB_KBD_BASE` that holds the 10-row PET keyboard matrix written by the MCU over the SPI-to-Wishbone bridge. It also snoops 6502 accesses to PIA1 so it can supply the column byte for the row the CPU has selected. It sits between the Wishbone interconnect and the CPU data-bus mux. It is the responder end of the `wb_kbd_addr()` traffic the bridge initiates.

## Interface
- `DATA_WIDTH`, 8: Wishbone and CPU data width.
- `ROW_COUNT`, `KBD_ROW_COUNT` (10): number of matrix rows implemented.
- `clock_i`  in  1  system clock (64 MHz).
- `reset_ni`  in  1  reset; asynchronous assert, active-low.
- `wb_addr_i`  in  `KBD_ADDR_WIDTH`  row index (low address bits; base decode is done by the interconnect).
- `wb_data_i`  in  8  write data.
- `wb_data_o`  out  8  read data, valid with ack.
- `wb_we_i`  in  1  write enable.
- `wb_cyc_i`, `wb_stb_i`  in  1  Wishbone cycle/strobe.
- `wb_ack_o`  out  1  acknowledge.
- `wb_stall_o`  out  1  always 0.
- `pia1_cs_i`  in  1  CPU access targets PIA1.
- `cpu_rs_i`  in  `PIA_RS_WIDTH`  PIA register select.
- `cpu_we_i`  in  1  CPU write.
- `cpu_strobe_i`  in  1  one-cycle pulse marking CPU data valid / access completion.
- `cpu_data_i`  in  8  CPU write data.
- `kbd_col_o`  out  8  column byte for the selected row (active-low keys).

## Operation
- Storage: `ROW_COUNT` x 8 registers. All reset to 8'hFF (no key down).
- WB write (`cyc&stb&we`):
  - Row < `ROW_COUNT`: store `wb_data_i`.
  - Row 10–15: discarded, still acked.
- WB read: returns the row value; rows 10–15 return 8'hFF.
- Ack FSM, states IDLE and ACK:
  - IDLE→ACK on `cyc&stb`.
  - ACK→IDLE unconditionally.
  - `wb_ack_o` is high only in ACK, so there are no back-to-back acks.
  - Dropping `cyc` while in ACK still completes the ack. The write has already been applied.
- PIA snoop on `cpu_strobe_i & pia1_cs_i & cpu_we_i`:
  - `cpu_rs_i==PIA_CRA`: `cra2 <= cpu_data_i[2]`.
  - `cpu_rs_i==PIA_PORTA` and `cra2==1`: `row_sel <= cpu_data_i[3:0]`.
  - Writes with `cra2==0` (DDR access) do not change `row_sel`.
- `kbd_col_o`:
  - Equals `row[row_sel]` when `row_sel < ROW_COUNT`, else 8'hFF.
  - The CPU-side mux gates it onto the bus for PORTB reads.
- Reset values: `row_sel`=0, `cra2`=0, `wb_ack_o`=0, `wb_data_o`=0, `kbd_col_o`=8'hFF.
- Reset mid-transaction aborts the ack. The bridge retries.

## Timing
- `wb_ack_o` rises on the clock edge after `stb` is sampled: 1-cycle latency. `wb_data_o` is registered alongside it.
- The WB write takes effect at the edge that enters ACK.
- `kbd_col_o` is registered. It reflects a `row_sel` change or a row write one cycle after the causing edge.
- Simultaneous WB write to the selected row and CPU PORTB read: the CPU sees the old value. The new value appears the next cycle.
- Simultaneous `row_sel` update and WB write: both are applied. The output follows the new row one cycle later.
- PET CPU cycles are ≥1 µs, so the 1-cycle output latency is always met before CPU data sampling.

## Configuration
- `KBD_WB_READBACK_EN`
  - Defined: WB reads return stored row data as above.
  - Undefined: the `wb_data_o` register and read mux are removed. `wb_data_o` is tied to 0, and reads are still acked.

## Structure
- Add to `common_pkg`:
  - `KBD_COL_RESET = 8'hFF`.
  - `KBD_ROW_SEL_WIDTH = 4`.
  - Typedef `kbd_row_t` (`logic [DATA_WIDTH-1:0]`).
- Reuse `KBD_ROW_COUNT`, `KBD_ADDR_WIDTH`, `PIA_*` and `WB_KBD_BASE` from `common_pkg`.
- One sub-module: `pia_row_select`, which holds the CRA/PORTA snoop logic (`cra2`, `row_sel`). The matrix storage and WB FSM stay in the top module.

## Test plan
- After reset, WB read row 3 → ack after 1 cycle, data 8'hFF. `kbd_col_o`=8'hFF.
- WB write row 9=8'hFE, then CPU writes CRA=8'h04 and PORTA=8'h09 → `kbd_col_o`=8'hFE one cycle later.
- CPU writes CRA=8'h00 then PORTA=8'h05 → `row_sel` stays 9. WB write row 12=8'h00 is acked; a read of row 12 returns 8'hFF.
- `row_sel`=2, WB write row 2=8'hBF in the same cycle as the CPU strobe → old value that cycle, 8'hBF next cycle.
- `stb` held 3 cycles → exactly one ack per two-cycle IDLE/ACK pass, never two consecutive. With readback disabled, read data = 8'h00.
- Assert `reset_ni` low while in ACK → ack drops asynchronously, all rows read 8'hFF afterwards.
